// File: rtl/flappy_pipe_field.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// flappy_pipe_field
//
// Generates and scrolls NUM_PIPES obstacle pipes at a constant horizontal
// spacing. Each pipe gets a pseudo-random gap-centre height from an internal
// 16-bit Galois LFSR when it spawns at game start and whenever it wraps
// around the left edge. Counts pipes that scroll past the bird column and
// freezes everything while the game is lost.
//
// Ports:
//   Clk         system clock
//   Reset       asynchronous, active-high reset
//   Start       level; starts a game from IDLE, returns to IDLE from LOST
//   Lost        level; collision reported by the game controller
//   Speed[1:0]  pixels per movement tick minus one, sampled on each tick
//   PipePosX    flattened pipe X positions, pipe i at [i*X_W +: X_W]
//   PipePosY    flattened gap-centre Y positions, same packing
//   PipeValid   one bit per pipe, 1 = pipe is drawn
//   ScorePulse  one-cycle pulse when a pipe crosses BIRD_X
//   Score       saturating count of pipes passed
//   Running     high while in the RUN state
// -----------------------------------------------------------------------------
module flappy_pipe_field #(
    parameter int unsigned NUM_PIPES    = 3,
    parameter int unsigned X_W          = 10,
    parameter int unsigned SPAWN_X      = 640,
    parameter int unsigned PIPE_SPACING = 240,
    parameter int unsigned BIRD_X       = 160,
    parameter int unsigned GAP_MIN      = 25,
    parameter int unsigned GAP_BITS     = 8,
    parameter int unsigned TICK_DIV     = 1024,
    parameter int unsigned SCORE_W      = 8,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Start,
    input  logic                       Lost,
    input  logic [1:0]                 Speed,
    output logic [NUM_PIPES*X_W-1:0]   PipePosX,
    output logic [NUM_PIPES*X_W-1:0]   PipePosY,
    output logic [NUM_PIPES-1:0]       PipeValid,
    output logic                       ScorePulse,
    output logic [SCORE_W-1:0]         Score,
    output logic                       Running
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [15:0]      SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0]      LFSR_MASK = 16'hB400;
    // Extra bit on X arithmetic so the respawn sum and compares never wrap.
    localparam logic [X_W:0]     WRAP_DIST = (X_W + 1)'(NUM_PIPES * PIPE_SPACING);
    localparam logic [X_W:0]     BIRD_X_E  = (X_W + 1)'(BIRD_X);
    localparam logic [X_W-1:0]   GAP_MIN_X = X_W'(GAP_MIN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOST = 2'd2
    } state_t;

    // Low GAP_BITS of v rotated left by n (n in 0..15).
    function automatic logic [GAP_BITS-1:0] rotl_slice(input logic [15:0] v,
                                                       input int unsigned n);
        logic [GAP_BITS-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < GAP_BITS; k++) begin
            r[k] = v[(k + 16 - n) % 16];
        end
        return r;
    endfunction

    state_t                  r_state;
    state_t                  w_state_next;
    logic [15:0]             r_lfsr;
    logic [15:0]             w_lfsr_next;
    logic [PRE_W-1:0]        r_prescale;
    logic [X_W-1:0]          r_pos_x [NUM_PIPES];
    logic [X_W-1:0]          r_pos_y [NUM_PIPES];
    logic [NUM_PIPES-1:0]    r_valid;
    logic [SCORE_W-1:0]      r_score;
    logic                    r_score_pulse;

    logic                    w_start_game;
    logic                    w_tick;
    logic                    w_to_idle;
    logic [X_W:0]            w_step;
    logic [X_W-1:0]          w_respawn_y;
    logic [X_W-1:0]          w_spawn_x   [NUM_PIPES];
    logic [X_W-1:0]          w_spawn_y   [NUM_PIPES];
    logic [X_W-1:0]          w_x_next    [NUM_PIPES];
    logic [NUM_PIPES-1:0]    w_respawn;
    logic [NUM_PIPES-1:0]    w_cross;

    // Galois LFSR, shifting right; free-running in every state.
    assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_MASK : 16'h0000);
    assign w_step      = (X_W + 1)'(Speed) + (X_W + 1)'(1);
    assign w_respawn_y = GAP_MIN_X + X_W'(r_lfsr[GAP_BITS-1:0]);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of block order.
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_state_next = r_state;
        w_start_game = 1'b0;
        w_tick       = 1'b0;
        w_to_idle    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Start && !Lost) begin
                    w_state_next = ST_RUN;
                    w_start_game = 1'b1;
                end
            end
            ST_RUN: begin
                if (Lost) begin
                    w_state_next = ST_LOST;
                end else begin
                    w_tick = (r_prescale == PRE_LAST);
                end
            end
            ST_LOST: begin
                if (Start && !Lost) begin
                    w_state_next = ST_IDLE;
                    w_to_idle    = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------- per-pipe logic
    genvar g;
    generate
        for (g = 0; g < NUM_PIPES; g++) begin : g_pipe
            localparam logic [X_W-1:0] SPAWN_XI = X_W'(SPAWN_X + g * PIPE_SPACING);
            logic [X_W:0] w_x_ext;

            assign w_x_ext      = {1'b0, r_pos_x[g]};
            assign w_spawn_x[g] = SPAWN_XI;
            assign w_spawn_y[g] = GAP_MIN_X + X_W'(rotl_slice(r_lfsr, (3 * g) % 16));
            // A pipe that would reach X <= 0 jumps right by the full field
            // length, keeping the spacing to its neighbours exact.
            assign w_respawn[g] = (w_x_ext <= w_step);
            assign w_x_next[g]  = w_respawn[g] ? X_W'(w_x_ext + WRAP_DIST - w_step)
                                               : X_W'(w_x_ext - w_step);
            assign w_cross[g]   = (w_x_ext >= BIRD_X_E) && ({1'b0, w_x_next[g]} < BIRD_X_E);

            assign PipePosX[g*X_W +: X_W] = r_pos_x[g];
            assign PipePosY[g*X_W +: X_W] = r_pos_y[g];
        end
    endgenerate

    // ------------------------------------------------------------ datapath
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_lfsr        <= SEED_EFF;
            r_prescale    <= '0;
            r_valid       <= '0;
            r_score       <= '0;
            r_score_pulse <= 1'b0;
            // NOTE: the pipe arrays are reset element by element because the
            // renderer must see all-zero positions straight out of reset.
            for (int i = 0; i < NUM_PIPES; i++) begin
                r_pos_x[i] <= '0;
                r_pos_y[i] <= '0;
            end
        end else begin
            r_lfsr        <= w_lfsr_next;
            r_score_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_prescale <= '0;
                    if (w_start_game) begin
                        r_valid <= '1;
                        r_score <= '0;
                        for (int i = 0; i < NUM_PIPES; i++) begin
                            r_pos_x[i] <= w_spawn_x[i];
                            r_pos_y[i] <= w_spawn_y[i];
                        end
                    end
                end
                ST_RUN: begin
                    // Lost freezes the field on this edge, even on a tick.
                    if (!Lost) begin
                        r_prescale <= w_tick ? '0 : r_prescale + PRE_W'(1);
                        if (w_tick) begin
                            for (int i = 0; i < NUM_PIPES; i++) begin
                                r_pos_x[i] <= w_x_next[i];
                                if (w_respawn[i]) begin
                                    r_pos_y[i] <= w_respawn_y;
                                end
                            end
                            // Pipe spacing guarantees at most one crossing.
                            if (|w_cross) begin
                                r_score_pulse <= 1'b1;
                                if (r_score != '1) begin
                                    r_score <= r_score + SCORE_W'(1);
                                end
                            end
                        end
                    end
                end
                ST_LOST: begin
                    if (w_to_idle) begin
                        r_valid <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign PipeValid  = r_valid;
    assign Score      = r_score;
    assign ScorePulse = r_score_pulse;
    assign Running    = (r_state == ST_RUN);

endmodule

// File: tb/tb_flappy_pipe_field.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_flappy_pipe_field
//
// Self-checking bench for flappy_pipe_field with a small two-pipe field.
// A directed vector table covers start, tick timing, Lost priority and the
// LOST/IDLE round trip; hand-written sequences cover crossing, respawn,
// faster speed crossing, score saturation and asynchronous reset; random
// stimulus is compared every cycle against a behavioural model.
// -----------------------------------------------------------------------------
module tb_flappy_pipe_field;

    localparam int NP   = 2;
    localparam int XW   = 10;
    localparam int SPX  = 300;
    localparam int SPC  = 100;
    localparam int BX   = 50;
    localparam int GMIN = 25;
    localparam int GB   = 8;
    localparam int TD   = 4;
    localparam int SW   = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_LOST = 2;

    logic               Clk   = 1'b0;
    logic               Reset = 1'b1;
    logic               Start = 1'b0;
    logic               Lost  = 1'b0;
    logic [1:0]         Speed = 2'd0;
    logic [NP*XW-1:0]   PipePosX;
    logic [NP*XW-1:0]   PipePosY;
    logic [NP-1:0]      PipeValid;
    logic               ScorePulse;
    logic [SW-1:0]      Score;
    logic               Running;

    flappy_pipe_field #(
        .NUM_PIPES    (NP),
        .X_W          (XW),
        .SPAWN_X      (SPX),
        .PIPE_SPACING (SPC),
        .BIRD_X       (BX),
        .GAP_MIN      (GMIN),
        .GAP_BITS     (GB),
        .TICK_DIV     (TD),
        .SCORE_W      (SW),
        .LFSR_SEED    (SEED)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Lost       (Lost),
        .Speed      (Speed),
        .PipePosX   (PipePosX),
        .PipePosY   (PipePosY),
        .PipeValid  (PipeValid),
        .ScorePulse (ScorePulse),
        .Score      (Score),
        .Running    (Running)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int get_x(input int p);
        return int'(PipePosX[p*XW +: XW]);
    endfunction

    function automatic int get_y(input int p);
        return int'(PipePosY[p*XW +: XW]);
    endfunction

    // ----------------------------------------------------- reference model
    int          m_state;
    logic [15:0] m_lfsr;
    int          m_pre;
    int          m_x [NP];
    int          m_y [NP];
    int          m_valid;
    int          m_score;
    int          m_pulse;

    function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic logic [15:0] rotl16(input logic [15:0] v, input int n);
        if (n == 0) return v;
        return (v << n) | (v >> (16 - n));
    endfunction

    task automatic model_reset();
        m_state = M_IDLE;
        m_lfsr  = SEED;
        m_pre   = 0;
        m_valid = 0;
        m_score = 0;
        m_pulse = 0;
        for (int i = 0; i < NP; i++) begin
            m_x[i] = 0;
            m_y[i] = 0;
        end
    endtask

    task automatic model_step(input bit st, input bit lo, input int spd);
        logic [15:0] cur;
        bit          crossed;
        int          s;
        int          nx;
        cur     = m_lfsr;
        m_lfsr  = lfsr_adv(cur);
        m_pulse = 0;
        case (m_state)
            M_IDLE: begin
                m_pre = 0;
                if (st && !lo) begin
                    m_state = M_RUN;
                    m_valid = (1 << NP) - 1;
                    m_score = 0;
                    for (int i = 0; i < NP; i++) begin
                        m_x[i] = SPX + i * SPC;
                        m_y[i] = GMIN + (int'(rotl16(cur, (3 * i) % 16)) % (1 << GB));
                    end
                end
            end
            M_RUN: begin
                if (lo) begin
                    m_state = M_LOST;
                end else if (m_pre == TD - 1) begin
                    m_pre   = 0;
                    s       = spd + 1;
                    crossed = 0;
                    for (int i = 0; i < NP; i++) begin
                        if (m_x[i] > s) begin
                            nx = m_x[i] - s;
                        end else begin
                            nx     = m_x[i] + NP * SPC - s;
                            m_y[i] = GMIN + (int'(cur) % (1 << GB));
                        end
                        if (m_x[i] >= BX && nx < BX) crossed = 1;
                        m_x[i] = nx;
                    end
                    if (crossed) begin
                        m_pulse = 1;
                        if (m_score < (1 << SW) - 1) m_score++;
                    end
                end else begin
                    m_pre++;
                end
            end
            default: begin
                if (st && !lo) begin
                    m_state = M_IDLE;
                    m_valid = 0;
                end
            end
        endcase
    endtask

    task automatic compare_model();
        check("model running", int'(Running), int'(m_state == M_RUN));
        check("model valid", int'(PipeValid), m_valid);
        check("model score", int'(Score), m_score);
        check("model pulse", int'(ScorePulse), m_pulse);
        for (int i = 0; i < NP; i++) begin
            check($sformatf("model x%0d", i), get_x(i), m_x[i]);
            check($sformatf("model y%0d", i), get_y(i), m_y[i]);
        end
    endtask

    // One clock: inputs already set at the preceding negedge, outputs
    // compared at the following negedge.
    task automatic cycle();
        bit st;
        bit lo;
        int spd;
        st  = Start;
        lo  = Lost;
        spd = int'(Speed);
        @(posedge Clk);
        model_step(st, lo, spd);
        @(negedge Clk);
        compare_model();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        Start = 1'b0;
        Lost  = 1'b0;
        Speed = 2'd0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        model_reset();
        compare_model();
    endtask

    task automatic run_until_x(input int p, input int target, input int budget);
        int n;
        n = 0;
        while (get_x(p) != target && n < budget) begin
            cycle();
            n++;
        end
        check($sformatf("reach x%0d=%0d", p, target), get_x(p), target);
    endtask

    task automatic wait_move(input int p, input int budget);
        int old;
        int n;
        old = get_x(p);
        n   = 0;
        do begin
            cycle();
            n++;
        end while (get_x(p) == old && n < budget);
    endtask

    // -------------------------------------------------------- vector table
    typedef struct {
        bit         start;
        bit         lost;
        logic [1:0] speed;
        bit         exp_run;
        logic [1:0] exp_valid;
        int         exp_x0;     // -1: not checked
        int         exp_x1;
        int         exp_score;
        bit         exp_pulse;
    } vec_t;

    function automatic vec_t mk(input bit st, input bit lo, input logic [1:0] sp,
                                input bit run, input logic [1:0] v,
                                input int x0, input int x1, input int sc);
        vec_t r;
        r.start     = st;
        r.lost      = lo;
        r.speed     = sp;
        r.exp_run   = run;
        r.exp_valid = v;
        r.exp_x0    = x0;
        r.exp_x1    = x1;
        r.exp_score = sc;
        r.exp_pulse = 1'b0;
        return r;
    endfunction

    vec_t vecs[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int n;

        // Start, then three non-tick cycles (Speed ignored), tick, etc.
        vecs.push_back(mk(1, 0, 2'd0, 1, 2'b11, 300, 400, 0));
        vecs.push_back(mk(0, 0, 2'd2, 1, 2'b11, 300, 400, 0));
        vecs.push_back(mk(0, 0, 2'd2, 1, 2'b11, 300, 400, 0));
        vecs.push_back(mk(0, 0, 2'd2, 1, 2'b11, 300, 400, 0));
        vecs.push_back(mk(0, 0, 2'd0, 1, 2'b11, 299, 399, 0));
        vecs.push_back(mk(0, 0, 2'd0, 1, 2'b11, 299, 399, 0));
        vecs.push_back(mk(0, 0, 2'd0, 1, 2'b11, 299, 399, 0));
        vecs.push_back(mk(0, 0, 2'd0, 1, 2'b11, 299, 399, 0));
        vecs.push_back(mk(0, 0, 2'd0, 1, 2'b11, 298, 398, 0));
        vecs.push_back(mk(0, 0, 2'd0, 1, 2'b11, 298, 398, 0));
        vecs.push_back(mk(0, 0, 2'd0, 1, 2'b11, 298, 398, 0));
        vecs.push_back(mk(0, 0, 2'd0, 1, 2'b11, 298, 398, 0));
        // Lost on the tick cycle: no movement.
        vecs.push_back(mk(0, 1, 2'd0, 0, 2'b11, 298, 398, 0));
        // Lost beats Start in LOST.
        vecs.push_back(mk(1, 1, 2'd0, 0, 2'b11, 298, 398, 0));
        vecs.push_back(mk(0, 0, 2'd0, 0, 2'b11, 298, 398, 0));
        vecs.push_back(mk(1, 0, 2'd0, 0, 2'b00, -1, -1, 0));
        // Lost beats Start in IDLE.
        vecs.push_back(mk(1, 1, 2'd0, 0, 2'b00, -1, -1, 0));
        vecs.push_back(mk(0, 0, 2'd0, 0, 2'b00, -1, -1, 0));
        vecs.push_back(mk(1, 0, 2'd0, 1, 2'b11, 300, 400, 0));

        do_reset();
        check("reset running", int'(Running), 0);
        check("reset posx", int'(PipePosX), 0);

        for (int v = 0; v < vecs.size(); v++) begin
            Start = vecs[v].start;
            Lost  = vecs[v].lost;
            Speed = vecs[v].speed;
            cycle();
            check($sformatf("vec%0d running", v), int'(Running), int'(vecs[v].exp_run));
            check($sformatf("vec%0d valid", v), int'(PipeValid), int'(vecs[v].exp_valid));
            if (vecs[v].exp_x0 >= 0) begin
                check($sformatf("vec%0d x0", v), get_x(0), vecs[v].exp_x0);
                check($sformatf("vec%0d x1", v), get_x(1), vecs[v].exp_x1);
            end
            check($sformatf("vec%0d score", v), int'(Score), vecs[v].exp_score);
            check($sformatf("vec%0d pulse", v), int'(ScorePulse), int'(vecs[v].exp_pulse));
            if (v == 0) begin
                for (int i = 0; i < NP; i++) begin
                    check($sformatf("spawn y%0d in range", i),
                          int'(get_y(i) >= 25 && get_y(i) <= 280), 1);
                end
            end
        end
        Start = 1'b0;
        Lost  = 1'b0;
        Speed = 2'd0;

        // Pipe 0 crosses the bird column 50 -> 49.
        run_until_x(0, 50, 1200);
        wait_move(0, 8);
        check("cross x0", get_x(0), 49);
        check("cross pulse", int'(ScorePulse), 1);
        check("cross score", int'(Score), 1);
        cycle();
        check("cross pulse one cycle", int'(ScorePulse), 0);
        check("cross score hold", int'(Score), 1);

        // Pipe 0 respawns from X=1.
        run_until_x(0, 1, 400);
        wait_move(0, 8);
        check("respawn x0", get_x(0), 200);
        check("respawn spacing", get_x(0) - get_x(1), 100);
        check("respawn y0 in range", int'(get_y(0) >= 25 && get_y(0) <= 280), 1);

        // Speed 3 crossing 52 -> 48.
        run_until_x(1, 52, 400);
        Speed = 2'd3;
        wait_move(1, 8);
        Speed = 2'd0;
        check("fast cross x1", get_x(1), 48);
        check("fast cross pulse", int'(ScorePulse), 1);
        check("fast cross score", int'(Score), 2);

        // Two more crossings: score saturates at 3.
        pulses = 0;
        n      = 0;
        while (pulses < 2 && n < 2500) begin
            cycle();
            if (ScorePulse) pulses++;
            n++;
        end
        check("saturation pulses", pulses, 2);
        check("saturated score", int'(Score), 3);

        // Lose, return to IDLE with score retained, restart clears it.
        Lost = 1'b1;
        cycle();
        check("lost running", int'(Running), 0);
        Lost  = 1'b0;
        Start = 1'b1;
        cycle();
        check("idle valid", int'(PipeValid), 0);
        check("idle score kept", int'(Score), 3);
        cycle();
        check("restart running", int'(Running), 1);
        check("restart score", int'(Score), 0);
        check("restart x0", get_x(0), 300);
        check("restart x1", get_x(1), 400);
        Start = 1'b0;

        // Random stimulus against the model.
        for (int c = 0; c < 4000; c++) begin
            Start = ($urandom_range(0, 29) == 0);
            Lost  = ($urandom_range(0, 799) == 0);
            Speed = 2'($urandom_range(0, 3));
            cycle();
        end

        // Get into RUN, then assert Reset between clock edges.
        Lost  = 1'b0;
        Start = 1'b1;
        n     = 0;
        while (!Running && n < 4) begin
            cycle();
            n++;
        end
        Start = 1'b0;
        repeat (6) cycle();
        check("pre-reset running", int'(Running), 1);
        Reset = 1'b1;
        #1;
        check("async reset posx", int'(PipePosX), 0);
        check("async reset posy", int'(PipePosY), 0);
        check("async reset valid", int'(PipeValid), 0);
        check("async reset score", int'(Score), 0);
        check("async reset pulse", int'(ScorePulse), 0);
        check("async reset running", int'(Running), 0);
        do_reset();
        Start = 1'b1;
        cycle();
        Start = 1'b0;
        repeat (8) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
